// File: rtl/prefetch_queue.sv
// prefetch_queue: code-byte prefetcher between the bus interface unit and the
// instruction decoder. Fetches words at CS:fetch_ip over a request/acknowledge
// bus and buffers up to DEPTH bytes. A new IP flushes the queue and restarts.
// Optional macro PREFETCH_BYPASS_EN: an accepted ack into an empty queue is
// presented on the FIFO outputs in the same cycle and may be consumed there.
//
// Memory handshake: mem_access is a registered request that rises together
// with a registered mem_address and holds both stable until the single-cycle
// mem_ack; mem_data is valid only in the mem_ack cycle. mem_access drops in
// the cycle after the ack, so there is always an idle cycle between requests.
// Decoder side: fifo_empty=0 means fifo_rd_data is a valid head byte;
// fifo_rd_en with fifo_empty=0 pops it at the clock edge, otherwise ignored.
module prefetch_queue #(
  parameter int DEPTH = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cs,
  input  logic        load_new_ip,
  input  logic [15:0] new_ip,
  output logic        mem_access,
  output logic [18:0] mem_address,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  input  logic        fifo_rd_en,
  output logic [7:0]  fifo_rd_data,
  output logic        fifo_empty,
  output logic [15:0] fetch_ip,
  output logic [1:0]  dbg_state_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t        state_q;
  logic          mem_access_q;
  logic [18:0]   mem_address_q;
  logic [15:0]   fetch_ip_q;
  logic [7:0]    buf_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  logic [1:0]    fetch_size;
  logic [CW-1:0] fetch_size_c;
  logic [CW-1:0] free_space;
  logic [19:0]   phys_addr;
  logic          accept;
  logic [7:0]    first_byte;
  logic [1:0]    push_n;
  logic          pop;
  logic [7:0]    wr_byte0;
  logic [7:0]    wr_byte1;
  logic          queue_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign queue_empty  = (count_q == '0);
  assign fetch_size   = fetch_ip_q[0] ? 2'd1 : 2'd2;
  assign fetch_size_c = CW'(fetch_size);
  assign free_space   = DEPTH_C - count_q;
  assign phys_addr    = {cs, 4'b0000} + {4'b0000, fetch_ip_q};
  // An ack only delivers bytes if no flush is requested in the same cycle.
  assign accept       = (state_q == REQ) && mem_ack && !load_new_ip;
  assign first_byte   = fetch_ip_q[0] ? mem_data[15:8] : mem_data[7:0];

  // Decide how many bytes are written and whether the head is popped.
  always_comb begin
    push_n   = 2'd0;
    pop      = 1'b0;
    wr_byte0 = first_byte;
    wr_byte1 = mem_data[15:8];
    if (accept) begin
      push_n = fetch_size;
    end
`ifdef PREFETCH_BYPASS_EN
    // First byte goes straight to the decoder; only the remainder is stored.
    if (accept && queue_empty && fifo_rd_en) begin
      push_n   = fetch_size - 2'd1;
      wr_byte0 = mem_data[15:8];
    end
`endif
    if (!load_new_ip && !queue_empty && fifo_rd_en) begin
      pop = 1'b1;
    end
  end

  // Decoder-facing outputs.
  always_comb begin
`ifdef PREFETCH_BYPASS_EN
    fifo_empty   = queue_empty && !accept;
    fifo_rd_data = !queue_empty ? buf_q[rd_ptr_q] :
                   (accept ? first_byte : 8'h00);
`else
    fifo_empty   = queue_empty;
    fifo_rd_data = !queue_empty ? buf_q[rd_ptr_q] : 8'h00;
`endif
  end

  // Byte queue storage, pointers and occupancy; a new IP empties it.
  always_ff @(posedge clk) begin
    if (reset || load_new_ip) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_n != 2'd0) begin
        buf_q[wr_ptr_q] <= wr_byte0;
      end
      if (push_n == 2'd2) begin
        buf_q[ptr_inc(wr_ptr_q)] <= wr_byte1;
      end
      if (push_n == 2'd2) begin
        wr_ptr_q <= ptr_inc(ptr_inc(wr_ptr_q));
      end else if (push_n == 2'd1) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CW'(push_n) - CW'(pop);
    end
  end

  // Fetch FSM: issues requests, tracks fetch_ip, swallows aborted acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_access_q  <= 1'b0;
      mem_address_q <= '0;
      fetch_ip_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_new_ip) begin
            fetch_ip_q <= new_ip;
          end else if (free_space >= fetch_size_c) begin
            state_q       <= REQ;
            mem_access_q  <= 1'b1;
            mem_address_q <= phys_addr[19:1];
          end
        end
        REQ: begin
          if (load_new_ip) begin
            fetch_ip_q <= new_ip;
            if (mem_ack) begin
              state_q      <= IDLE;
              mem_access_q <= 1'b0;
            end else begin
              state_q <= ABORT;
            end
          end else if (mem_ack) begin
            fetch_ip_q   <= fetch_ip_q + {14'd0, fetch_size};
            state_q      <= IDLE;
            mem_access_q <= 1'b0;
          end
        end
        ABORT: begin
          if (load_new_ip) begin
            fetch_ip_q <= new_ip;
          end
          if (mem_ack) begin
            state_q      <= IDLE;
            mem_access_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          mem_access_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_access  = mem_access_q;
  assign mem_address = mem_address_q;
  assign fetch_ip    = fetch_ip_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue (DEPTH=6). Inputs change on the falling
// edge; outputs are checked on the falling edge after settling.
module tb_prefetch_queue;

  logic        clk;
  logic        reset;
  logic [15:0] cs;
  logic        load_new_ip;
  logic [15:0] new_ip;
  logic        mem_access;
  logic [18:0] mem_address;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic [15:0] fetch_ip;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  prefetch_queue #(.DEPTH(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .load_new_ip  (load_new_ip),
    .new_ip       (new_ip),
    .mem_access   (mem_access),
    .mem_address  (mem_address),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fetch_ip     (fetch_ip),
    .dbg_state_o  (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: the rising edge happens, then we are back at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag, input int max_cycles);
    int n = 0;
    while (!mem_access && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, {31'd0, mem_access}, 32'd1);
  endtask

  // Single-cycle acknowledge with data.
  task automatic ack(input logic [15:0] d);
    mem_ack  = 1'b1;
    mem_data = d;
    step();
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    #1;
  endtask

  // Pop the head and compare it against the scoreboard.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_nonempty"}, {31'd0, fifo_empty}, 32'd0);
    check(tag, {24'd0, fifo_rd_data}, {24'd0, e});
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    #1;
  endtask

  task automatic flush(input logic [15:0] ip, input logic [15:0] seg);
    load_new_ip = 1'b1;
    new_ip      = ip;
    cs          = seg;
    step();
    load_new_ip = 1'b0;
    exp_q.delete();
    #1;
  endtask

  initial begin
    reset = 1'b1; cs = 16'hF000; load_new_ip = 1'b0; new_ip = 16'h0000;
    mem_ack = 1'b0; mem_data = 16'h0000; fifo_rd_en = 1'b0;
    step(); step();
    check("rst_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_rd_data", {24'd0, fifo_rd_data}, 32'd0);
    check("rst_access", {31'd0, mem_access}, 32'd0);
    check("rst_addr", {13'd0, mem_address}, 32'd0);
    check("rst_fetch_ip", {16'd0, fetch_ip}, 32'd0);
    reset = 1'b0;

    // 1: first even fetch from F000:0000.
    wait_req("t1_req", 4);
    check("t1_addr", {13'd0, mem_address}, 32'h78000);
    step();
    check("t1_hold_access", {31'd0, mem_access}, 32'd1);
    check("t1_hold_addr", {13'd0, mem_address}, 32'h78000);
    ack(16'hBBAA);
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    check("t1_access_drop", {31'd0, mem_access}, 32'd0);
    check("t1_fetch_ip", {16'd0, fetch_ip}, 32'h0002);
    pop_check("t1_pop0");
    pop_check("t1_pop1");
    check("t1_empty", {31'd0, fifo_empty}, 32'd1);
    check("t1_next_addr", {13'd0, mem_address}, 32'h78001);
    ack(16'h2211);
    check("t1_fetch_ip4", {16'd0, fetch_ip}, 32'h0004);

    // 2: odd restart IP fetches only the high byte.
    flush(16'h0003, 16'h0000);
    check("t2_flush_empty", {31'd0, fifo_empty}, 32'd1);
    check("t2_flush_ip", {16'd0, fetch_ip}, 32'h0003);
    wait_req("t2_req", 4);
    check("t2_addr", {13'd0, mem_address}, 32'h00001);
    ack(16'h1234);
    exp_q.push_back(8'h12);
    check("t2_fetch_ip", {16'd0, fetch_ip}, 32'h0004);
    pop_check("t2_pop");
    check("t2_empty", {31'd0, fifo_empty}, 32'd1);
    check("t2_next_addr", {13'd0, mem_address}, 32'h00002);

    // 3: fill the queue to DEPTH and watch the free-space throttle.
    ack(16'h0201);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    wait_req("t3_req2", 4);
    ack(16'h0403);
    exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    wait_req("t3_req3", 4);
    ack(16'h0605);
    exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    for (int i = 0; i < 5; i++) step();
    check("t3_full_noreq", {31'd0, mem_access}, 32'd0);
    check("t3_fetch_ip", {16'd0, fetch_ip}, 32'h000A);
    pop_check("t3_pop0");
    for (int i = 0; i < 3; i++) step();
    check("t3_cnt5_noreq", {31'd0, mem_access}, 32'd0);
    pop_check("t3_pop1");
    check("t3_pop_edge_noreq", {31'd0, mem_access}, 32'd0);
    wait_req("t3_cnt4_req", 3);
    check("t3_addr", {13'd0, mem_address}, 32'h00005);

    // 4: flush during an outstanding request; the late ack is dropped.
    flush(16'h0100, 16'h0000);
    check("t4_empty", {31'd0, fifo_empty}, 32'd1);
    check("t4_still_access", {31'd0, mem_access}, 32'd1);
    check("t4_fetch_ip", {16'd0, fetch_ip}, 32'h0100);
    step(); step();
    check("t4_wait_access", {31'd0, mem_access}, 32'd1);
    ack(16'hDEAD);
    check("t4_access_drop", {31'd0, mem_access}, 32'd0);
    check("t4_discard", {31'd0, fifo_empty}, 32'd1);
    wait_req("t4_req", 4);
    check("t4_addr", {13'd0, mem_address}, 32'h00080);

    // Flush in the same cycle as the ack: data dropped, back to IDLE.
    mem_ack = 1'b1; mem_data = 16'hBEEF;
    load_new_ip = 1'b1; new_ip = 16'hFFFE; cs = 16'hFFFF;
    step();
    mem_ack = 1'b0; load_new_ip = 1'b0; exp_q.delete();
    #1;
    check("t4b_access", {31'd0, mem_access}, 32'd0);
    check("t4b_empty", {31'd0, fifo_empty}, 32'd1);
    check("t4b_fetch_ip", {16'd0, fetch_ip}, 32'hFFFE);

    // 5: 1 MB wrap of the physical address, 64 KB wrap of fetch_ip.
    wait_req("t5_req", 4);
    check("t5_addr", {13'd0, mem_address}, 32'h07FF7);
    ack(16'h7766);
    exp_q.push_back(8'h66); exp_q.push_back(8'h77);
    check("t5_fetch_ip", {16'd0, fetch_ip}, 32'h0000);
    pop_check("t5_pop0");
    pop_check("t5_pop1");
    check("t5_next_addr", {13'd0, mem_address}, 32'h7FFF8);

    // 6: ack into an empty queue with a pop in the same cycle.
    check("t6_pre_empty", {31'd0, fifo_empty}, 32'd1);
    mem_ack = 1'b1; mem_data = 16'h5A4B; fifo_rd_en = 1'b1;
    #1;
`ifdef PREFETCH_BYPASS_EN
    check("t6_bypass_valid", {31'd0, fifo_empty}, 32'd0);
    check("t6_bypass_data", {24'd0, fifo_rd_data}, 32'h4B);
    exp_q.push_back(8'h5A);
`else
    check("t6_no_bypass", {31'd0, fifo_empty}, 32'd1);
    exp_q.push_back(8'h4B); exp_q.push_back(8'h5A);
`endif
    step();
    mem_ack = 1'b0; mem_data = 16'h0000; fifo_rd_en = 1'b0;
    #1;
    check("t6_fetch_ip", {16'd0, fetch_ip}, 32'h0002);
    while (exp_q.size() > 0) pop_check("t6_pop");
    check("t6_drained", {31'd0, fifo_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
